// File: rtl/sprite_overlay.sv
// Two-stage sprite overlay: stage 1 computes the sprite hit and ROM address,
// stage 2 merges the ROM pixel (minus the key colour) over the incoming stream.
module sprite_overlay #(
    parameter int          SPRITE_W  = 16,
    parameter int          SPRITE_H  = 16,
    parameter logic [23:0] KEY_COLOR = 24'hFF_00_FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hcount_in,
    input  logic        hsync_in,
    input  logic [9:0]  vcount_in,
    input  logic        vsync_in,
    input  logic        blnk_in,
    input  logic [23:0] rgb_in,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    input  logic [1:0]  frame_sel,
    input  logic        mirror,
    input  logic        enable,
    output logic [9:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic [9:0]  hcount_out,
    output logic        hsync_out,
    output logic [9:0]  vcount_out,
    output logic        vsync_out,
    output logic        blnk_out,
    output logic [23:0] rgb_out
);

    localparam int          CW  = $clog2(SPRITE_W);
    localparam int          RW  = $clog2(SPRITE_H);
    localparam int          AW  = 2 + RW + CW;
    localparam logic [10:0] W11 = 11'(SPRITE_W);
    localparam logic [10:0] H11 = 11'(SPRITE_H);

    // Edge detector and per-frame shadow copies of the placement inputs
    logic        vsync_prev_q, vsync_prev_d;
    logic        en_s_q, en_s_d;
    logic        mirror_s_q, mirror_s_d;
    logic [1:0]  frame_s_q, frame_s_d;
    logic [9:0]  x_s_q, x_s_d;
    logic [9:0]  y_s_q, y_s_d;

    // Stage 1
    logic        hit_q, hit_d;
    logic [9:0]  rom_addr_q, rom_addr_d;
    logic [9:0]  s1_hcount_q, s1_hcount_d;
    logic        s1_hsync_q, s1_hsync_d;
    logic [9:0]  s1_vcount_q, s1_vcount_d;
    logic        s1_vsync_q, s1_vsync_d;
    logic        s1_blnk_q, s1_blnk_d;
    logic [23:0] s1_rgb_q, s1_rgb_d;

    // Stage 2
    logic [9:0]  hcount_out_q, hcount_out_d;
    logic        hsync_out_q, hsync_out_d;
    logic [9:0]  vcount_out_q, vcount_out_d;
    logic        vsync_out_q, vsync_out_d;
    logic        blnk_out_q, blnk_out_d;
    logic [23:0] rgb_out_q, rgb_out_d;

    logic          capture;
    logic [10:0]   x_end, y_end;
    logic [CW-1:0] col_raw, col;
    logic [RW-1:0] row;
    logic [AW-1:0] addr_cat;

    always_comb begin
        capture      = vsync_in & ~vsync_prev_q;
        vsync_prev_d = vsync_in;
        en_s_d       = capture ? enable    : en_s_q;
        mirror_s_d   = capture ? mirror    : mirror_s_q;
        frame_s_d    = capture ? frame_sel : frame_s_q;
        x_s_d        = capture ? xpos      : x_s_q;
        y_s_d        = capture ? ypos      : y_s_q;

        // 11-bit bounds so a box near the right/bottom edge clips instead of wrapping
        x_end = {1'b0, x_s_q} + W11;
        y_end = {1'b0, y_s_q} + H11;
        hit_d = en_s_q & ~blnk_in
              & ({1'b0, hcount_in} >= {1'b0, x_s_q}) & ({1'b0, hcount_in} < x_end)
              & ({1'b0, vcount_in} >= {1'b0, y_s_q}) & ({1'b0, vcount_in} < y_end);

        col_raw    = CW'(hcount_in - x_s_q);
        col        = mirror_s_q ? (CW'(SPRITE_W - 1) - col_raw) : col_raw;
        row        = RW'(vcount_in - y_s_q);
        addr_cat   = {frame_s_q, row, col};
        rom_addr_d = hit_d ? 10'(addr_cat) : 10'd0;

        s1_hcount_d = hcount_in;
        s1_hsync_d  = hsync_in;
        s1_vcount_d = vcount_in;
        s1_vsync_d  = vsync_in;
        s1_blnk_d   = blnk_in;
        s1_rgb_d    = rgb_in;

        // rom_data answers the address registered in stage 1
        hcount_out_d = s1_hcount_q;
        hsync_out_d  = s1_hsync_q;
        vcount_out_d = s1_vcount_q;
        vsync_out_d  = s1_vsync_q;
        blnk_out_d   = s1_blnk_q;
        rgb_out_d    = (hit_q && (rom_data != KEY_COLOR)) ? rom_data : s1_rgb_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev_q <= 1'b0;
            en_s_q       <= 1'b0;
            mirror_s_q   <= 1'b0;
            frame_s_q    <= 2'd0;
            x_s_q        <= 10'h3FF;
            y_s_q        <= 10'h3FF;
            hit_q        <= 1'b0;
            rom_addr_q   <= 10'd0;
            s1_hcount_q  <= 10'd0;
            s1_hsync_q   <= 1'b0;
            s1_vcount_q  <= 10'd0;
            s1_vsync_q   <= 1'b0;
            s1_blnk_q    <= 1'b0;
            s1_rgb_q     <= 24'd0;
            hcount_out_q <= 10'd0;
            hsync_out_q  <= 1'b0;
            vcount_out_q <= 10'd0;
            vsync_out_q  <= 1'b0;
            blnk_out_q   <= 1'b0;
            rgb_out_q    <= 24'd0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            en_s_q       <= en_s_d;
            mirror_s_q   <= mirror_s_d;
            frame_s_q    <= frame_s_d;
            x_s_q        <= x_s_d;
            y_s_q        <= y_s_d;
            hit_q        <= hit_d;
            rom_addr_q   <= rom_addr_d;
            s1_hcount_q  <= s1_hcount_d;
            s1_hsync_q   <= s1_hsync_d;
            s1_vcount_q  <= s1_vcount_d;
            s1_vsync_q   <= s1_vsync_d;
            s1_blnk_q    <= s1_blnk_d;
            s1_rgb_q     <= s1_rgb_d;
            hcount_out_q <= hcount_out_d;
            hsync_out_q  <= hsync_out_d;
            vcount_out_q <= vcount_out_d;
            vsync_out_q  <= vsync_out_d;
            blnk_out_q   <= blnk_out_d;
            rgb_out_q    <= rgb_out_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign hcount_out = hcount_out_q;
    assign hsync_out  = hsync_out_q;
    assign vcount_out = vcount_out_q;
    assign vsync_out  = vsync_out_q;
    assign blnk_out   = blnk_out_q;
    assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_sprite_overlay.sv
// Directed bench for sprite_overlay: each pixel is held for two clocks and the
// delayed outputs are compared with hand-computed values.
module tb_sprite_overlay;

    localparam logic [23:0] KEY   = 24'hFF_00_FF;
    localparam logic [23:0] GREEN = 24'h00_FF_00;
    localparam logic [23:0] RED   = 24'hFF_00_00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  hcount_in = '0, vcount_in = '0, xpos = '0, ypos = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, blnk_in = 1'b0;
    logic        mirror = 1'b0, enable = 1'b0;
    logic [1:0]  frame_sel = '0;
    logic [23:0] rgb_in = '0;
    logic [23:0] rom_data;
    logic [9:0]  rom_addr, hcount_out, vcount_out;
    logic        hsync_out, vsync_out, blnk_out;
    logic [23:0] rgb_out;
    int          rom_mode = 0;
    int          passed = 0, failed = 0, total = 0;

    logic [9:0]  hist_h [8];
    logic [9:0]  hist_v [8];
    logic        hist_hs [8];
    logic        hist_vs [8];
    logic        hist_b [8];
    logic [23:0] hist_rgb [8];

    sprite_overlay dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .vcount_in(vcount_in),
        .vsync_in(vsync_in), .blnk_in(blnk_in), .rgb_in(rgb_in),
        .xpos(xpos), .ypos(ypos), .frame_sel(frame_sel), .mirror(mirror),
        .enable(enable), .rom_addr(rom_addr), .rom_data(rom_data),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .vcount_out(vcount_out),
        .vsync_out(vsync_out), .blnk_out(blnk_out), .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    // Sprite ROM: mode 0 solid green, mode 1 column 0 transparent and the rest red
    always_comb begin
        rom_data = GREEN;
        if (rom_mode == 1)
            rom_data = (rom_addr[3:0] == 4'd0) ? KEY : RED;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, hold it for two clocks, check address and merged output
    task automatic px(input string tag, input int h, input int v, input logic b,
                      input logic [23:0] rgb, input logic [23:0] exp_rgb, input int exp_addr);
        logic [9:0] hh, vv;
        hh = h[9:0];
        vv = v[9:0];
        hcount_in = hh;
        vcount_in = vv;
        blnk_in   = b;
        rgb_in    = rgb;
        tick();
        if (exp_addr >= 0) chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        tick();
        chk({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
        chk({tag, "_hcnt"}, 32'(hcount_out), 32'(hh));
        $display("pixel %s h=%0d v=%0d rgb_out=%h addr=%h", tag, h, v, rgb_out, rom_addr);
    endtask

    task automatic vs_edge(input int x, input int y, input int fr, input logic mir, input logic en);
        logic [9:0] xx, yy;
        logic [1:0] ff;
        xx = x[9:0];
        yy = y[9:0];
        ff = fr[1:0];
        blnk_in = 1'b1;
        tick();
        xpos = xx; ypos = yy; frame_sel = ff; mirror = mir; enable = en;
        vsync_in = 1'b1;
        tick();
        tick();
        vsync_in = 1'b0;
        tick();
        blnk_in = 1'b0;
        $display("vsync edge x=%0d y=%0d frame=%0d mirror=%0b en=%0b", x, y, fr, mir, en);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Mid-line reset with a live pixel in flight
        hcount_in = 10'd300; vcount_in = 10'd20; hsync_in = 1'b1; rgb_in = 24'hABCDEF;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_rgb", 32'(rgb_out), 32'd0);
        chk("rst_hcnt", 32'(hcount_out), 32'd0);
        chk("rst_vcnt", 32'(vcount_out), 32'd0);
        chk("rst_hsync", 32'(hsync_out), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        hsync_in = 1'b0;
        $display("reset applied for 3 clocks mid-line");

        // Enabled but no vsync edge yet: pass-through
        xpos = 10'd100; ypos = 10'd50; enable = 1'b1;
        px("noedge", 100, 50, 1'b0, 24'h123456, 24'h123456, 0);

        // Placement with a solid green sprite
        rom_mode = 0;
        vs_edge(100, 50, 0, 1'b0, 1'b1);
        px("tl", 100, 50, 1'b0, 24'h111111, GREEN, 0);
        px("br", 115, 65, 1'b0, 24'h111111, GREEN, 10'h0FF);
        px("mid", 107, 57, 1'b0, 24'h111111, GREEN, 10'h077);
        px("right", 116, 50, 1'b0, 24'h222222, 24'h222222, 0);
        px("left", 99, 50, 1'b0, 24'h333333, 24'h333333, 0);
        px("below", 100, 66, 1'b0, 24'h444444, 24'h444444, 0);
        px("above", 100, 49, 1'b0, 24'h555555, 24'h555555, 0);

        // Transparency and mirroring
        rom_mode = 1;
        px("key_c0", 100, 50, 1'b0, 24'h010203, 24'h010203, -1);
        px("red_c1", 101, 50, 1'b0, 24'h010203, RED, 10'h001);
        px("red_c15", 115, 50, 1'b0, 24'h010203, RED, -1);
        vs_edge(100, 50, 0, 1'b1, 1'b1);
        px("mir_115", 115, 50, 1'b0, 24'h0A0B0C, 24'h0A0B0C, 0);
        px("mir_100", 100, 52, 1'b0, 24'h0A0B0C, RED, 10'h02F);

        // Tearing: xpos changes mid-frame without a vsync edge
        rom_mode = 0;
        vs_edge(100, 50, 0, 1'b0, 1'b1);
        px("tear_pre", 100, 55, 1'b0, 24'h777777, GREEN, -1);
        xpos = 10'd300;
        px("tear_old", 100, 56, 1'b0, 24'h777777, GREEN, -1);
        px("tear_new", 300, 56, 1'b0, 24'h777777, 24'h777777, 0);
        vs_edge(300, 50, 0, 1'b0, 1'b1);
        px("nxt_new", 300, 50, 1'b0, 24'h777777, GREEN, 0);
        px("nxt_old", 100, 50, 1'b0, 24'h777777, 24'h777777, 0);

        // Clipping at the right edge, and the 11-bit bound near the counter top
        vs_edge(630, 50, 0, 1'b0, 1'b1);
        px("clip_630", 630, 50, 1'b0, 24'h888888, GREEN, -1);
        px("clip_639", 639, 50, 1'b0, 24'h888888, GREEN, -1);
        px("clip_0", 0, 50, 1'b0, 24'h888888, 24'h888888, 0);
        px("clip_5", 5, 50, 1'b0, 24'h888888, 24'h888888, 0);
        vs_edge(1016, 50, 0, 1'b0, 1'b1);
        px("top_1016", 1016, 50, 1'b0, 24'h999999, GREEN, 0);
        px("top_3", 3, 50, 1'b0, 24'h999999, 24'h999999, 0);

        // Blanking inside the box
        vs_edge(100, 50, 0, 1'b0, 1'b1);
        px("blank", 105, 55, 1'b1, 24'h5A5A5A, 24'h5A5A5A, 0);

        // Frame select
        vs_edge(100, 50, 2, 1'b0, 1'b1);
        px("fr2_a", 100, 50, 1'b0, 24'h121212, GREEN, 10'h200);
        px("fr2_b", 110, 60, 1'b0, 24'h121212, GREEN, 10'h2AA);

        // Back-to-back stream: every output is its input exactly two clocks later
        for (int i = 0; i < 8; i++) begin
            hist_h[i]   = 10'(700 + i);
            hist_v[i]   = 10'(200 + 3 * i);
            hist_hs[i]  = i[0];
            hist_vs[i]  = i[1];
            hist_b[i]   = i[2];
            hist_rgb[i] = 24'(32'h10_2030 * (i + 1));
            hcount_in = hist_h[i]; vcount_in = hist_v[i]; hsync_in = hist_hs[i];
            vsync_in = hist_vs[i]; blnk_in = hist_b[i]; rgb_in = hist_rgb[i];
            tick();
            if (i >= 1) begin
                chk($sformatf("lat_h%0d", i), 32'(hcount_out), 32'(hist_h[i-1]));
                chk($sformatf("lat_v%0d", i), 32'(vcount_out), 32'(hist_v[i-1]));
                chk($sformatf("lat_hs%0d", i), 32'(hsync_out), 32'(hist_hs[i-1]));
                chk($sformatf("lat_vs%0d", i), 32'(vsync_out), 32'(hist_vs[i-1]));
                chk($sformatf("lat_b%0d", i), 32'(blnk_out), 32'(hist_b[i-1]));
                chk($sformatf("lat_rgb%0d", i), 32'(rgb_out), 32'(hist_rgb[i-1]));
                $display("stream step %0d hcount_out=%0d vcount_out=%0d", i, hcount_out, vcount_out);
            end
        end
        hsync_in = 1'b0; vsync_in = 1'b0; blnk_in = 1'b0;
        tick();

        // Reset mid-frame: sprite stays off until the next vsync edge
        vs_edge(100, 50, 0, 1'b0, 1'b1);
        px("pre_rst", 100, 50, 1'b0, 24'h246801, GREEN, -1);
        hcount_in = 10'd105;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        px("post_rst", 100, 50, 1'b0, 24'h246801, 24'h246801, 0);
        vs_edge(100, 50, 0, 1'b0, 1'b1);
        px("reappear", 100, 50, 1'b0, 24'h246801, GREEN, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sprite_overlay.md
SPRITE_OVERLAY -- requirements
Module: sprite_overlay

Interface
REQ-001 Parameter SPRITE_W, default 16, sprite width in pixels (power of two).
REQ-002 Parameter SPRITE_H, default 16, sprite height in pixels (power of two).
REQ-003 Parameter KEY_COLOR, default 24'hFF_00_FF, transparent colour; pixels of this value are not drawn.
REQ-004 Port clk  input  1  pixel clock; single clock domain.
REQ-005 Port rst  input  1  reset; synchronous and active-high.
REQ-006 Ports hcount_in[9:0], hsync_in, vcount_in[9:0], vsync_in, blnk_in, rgb_in[23:0]  input  timing/pixel stream from the preceding stage (Clouds output).
REQ-007 Port xpos  input  10  sprite left edge, screen pixels.
REQ-008 Port ypos  input  10  sprite top edge, screen pixels (vcount 0 = top).
REQ-009 Port frame_sel  input  2  animation frame index.
REQ-010 Port mirror  input  1  1 = draw sprite horizontally flipped.
REQ-011 Port enable  input  1  1 = sprite visible.
REQ-012 Port rom_addr  output  10  address to external sprite ROM, {frame, row[3:0], col[3:0]} for defaults.
REQ-013 Port rom_data  input  24  ROM pixel; valid exactly one clk after rom_addr is presented.
REQ-014 Ports hcount_out[9:0], hsync_out, vcount_out[9:0], vsync_out, blnk_out, rgb_out[23:0]  output  registered stream to the next stage.

Function
REQ-015 Latency SHALL be exactly 2 clk for every stream signal, in to out, with no bubbles.
REQ-016 vsync rising edge SHALL be detected as vsync_in=1 while a registered copy of vsync_in=0.
REQ-017 On that edge cycle xpos, ypos, frame_sel, mirror, enable SHALL be captured into shadow registers; the capture takes effect from the next clk.
REQ-018 Input changes at any other time SHALL be ignored until the next vsync rising edge (no mid-frame tearing).
REQ-019 Stage 1: hit = en_s & ~blnk_in & (hcount_in >= x_s) & (hcount_in < x_s+SPRITE_W) & (vcount_in >= y_s) & (vcount_in < y_s+SPRITE_H).
REQ-020 Bound sums SHALL be 11-bit unsigned; no wrap, so a sprite at x_s > 640-SPRITE_W is clipped at the right/bottom edge.
REQ-021 col = hcount_in - x_s (4 bits); with mirror_s, col = SPRITE_W-1 - (hcount_in - x_s); row = vcount_in - y_s (4 bits).
REQ-022 rom_addr SHALL be registered in stage 1 as {frame_s, row, col}; when hit=0 it SHALL hold 0.
REQ-023 Stage 1 SHALL register hit and all stream signals; stage 2 SHALL register them again into the outputs.
REQ-024 Stage 2: rgb_out = rom_data when hit_d1=1 and rom_data != KEY_COLOR; else rgb_in delayed 2 clk.
REQ-025 Capture cycle coinciding with an active pixel SHALL use the old shadow values for that pixel.
REQ-026 Behaviour SHALL be purely positional; no state machine beyond the edge detector and the 2-stage pipeline.

Reset
REQ-027 While rst=1 at a clk edge: all outputs, rom_addr, pipeline registers and vsync copy SHALL go to 0.
REQ-028 Reset values of the shadows: en_s=0, mirror_s=0, frame_s=0, x_s=10'h3FF, y_s=10'h3FF (nothing drawn).
REQ-029 Reset asserted mid-frame SHALL flush the pipeline; the sprite SHALL reappear only after the first vsync rising edge following rst deassertion.

Verification
REQ-030 Reset: rst=1 for 3 clk mid-line -> all outputs 0 next clk; with enable=1 and no vsync edge yet, rgb_out == rgb_in delayed 2 clk.
REQ-031 Placement: x=100, y=50, enable=1, vsync edge, ROM = solid 24'h00_FF_00 -> rgb_out green exactly for hcount 100..115, vcount 50..65; elsewhere rgb_in; rom_addr at (100,50) = 0.
REQ-032 Transparency/mirror: ROM col 0 = KEY_COLOR, others red; mirror=0 -> pixel x=100 shows rgb_in; mirror=1 -> pixel x=115 shows rgb_in, x=100 red.
REQ-033 Tearing: change xpos 100->300 at vcount 55 -> rest of frame still drawn at 100; next frame at 300.
REQ-034 Clipping/blanking: x=630 -> hcount 630..639 drawn, nothing wraps to column 0; blnk_in=1 inside the box -> rgb_in passed through.
REQ-035 Frame select: frame_sel=2 at vsync -> rom_addr[9:8]=2 for all hits in that frame; every frame, hsync/vsync/blnk/counts out == in delayed exactly 2 clk.
